// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for pipeline-boundary registers (occupancy states, ID/EX payload).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef logic [31:0] reg_bus_t;
    typedef logic [19:0] word_t;
    typedef logic [7:0]  opcode_wide_t;
    typedef logic [7:0]  ex_code_t;
    typedef logic [31:0] inst_addr_bus_t;

    typedef struct packed {
        reg_bus_t       rdata1;
        reg_bus_t       rdata2;
        word_t          imm1;
        word_t          imm2;
        opcode_wide_t   opcode;
        ex_code_t       ex_code;
        inst_addr_bus_t pc;
        logic [4:0]     waddr;
        logic           we;
        logic [1:0]     jump_bp;
    } id_ex_payload_t;

    localparam int ID_EX_W = $bits(id_ex_payload_t);

    // All-zero bundle is a NOP: no register write, no jump prediction.
    localparam id_ex_payload_t ID_EX_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-enabled counter that sticks at its all-ones maximum.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with a two-entry skid buffer,
// flush-to-bubble, occupancy output and saturating stall-bubble counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 160,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);
    occ_e              state, state_nxt;
    logic [DATA_W-1:0] m_data, s_data, m_nxt, s_nxt;
    logic              m_valid, in_xfer, out_xfer;

    assign m_valid   = state != EMPTY;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = state;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = m_valid && out_ready;

    // Flush wins over any same-cycle acceptance; the out-transfer still leaves.
    always_comb begin
        state_nxt = flush ? EMPTY :
                    state == EMPTY ? (in_xfer ? ONE : EMPTY) :
                    state == ONE   ? (in_xfer && !out_xfer ? FULL :
                                      !in_xfer && out_xfer ? EMPTY : ONE) :
                    (out_xfer ? ONE : FULL);
        m_nxt     = flush ? RESET_VAL :
                    state == FULL ? (out_xfer ? s_data : m_data) :
                    in_xfer && (state == EMPTY || out_xfer) ? in_data :
                    out_xfer ? RESET_VAL : m_data;
        s_nxt     = flush ? RESET_VAL :
                    state == FULL ? (out_xfer ? RESET_VAL : s_data) :
                    state == ONE && in_xfer && !out_xfer ? in_data : s_data;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= EMPTY;
            m_data   <= RESET_VAL;
            s_data   <= RESET_VAL;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            m_data   <= m_nxt;
            s_data   <= s_nxt;
            in_ready <= state_nxt != FULL;
        end

    sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_ready && !m_valid),
        .count (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random stimulus against a queue-based model of the stage.
module tb_pipe_stage_skid;
    localparam int          DW = 32;
    localparam int          CW = 4;
    localparam logic [31:0] RV = 32'hA5A5_0F0F;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, flush;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] bubble_cnt;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] q[$];
    logic          rdy_m;
    int            bub_m;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
        chk({tag, ".out_data"}, out_data, q.size() > 0 ? q[0] : RV);
        chk({tag, ".occupancy"}, DW'(occupancy), DW'(q.size()));
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(rdy_m));
        chk({tag, ".bubble_cnt"}, DW'(bubble_cnt), DW'(bub_m));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic fl, input string tag);
        logic ix, ox;
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        ix = iv && rdy_m;
        ox = ordy && q.size() > 0;
        @(posedge clk);
        if (ordy && q.size() == 0 && bub_m < (1 << CW) - 1) bub_m++;
        if (ox) void'(q.pop_front());
        if (fl) q.delete();
        else if (ix) q.push_back(id);
        rdy_m = q.size() < 2;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        q.delete(); rdy_m = 1'b0; bub_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] nxt;
        do_reset();
        // release cycle: in_ready still low, nothing accepted
        step(1'b1, 32'h99, 1'b0, 1'b0, "release");
        chk("release_ready", DW'(in_ready), 32'd1);
        // streaming 1..8 with downstream always ready
        for (int k = 1; k <= 8; k++) step(1'b1, DW'(k), 1'b1, 1'b0, "stream");
        chk("stream_bubble", DW'(bubble_cnt), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, "stream_drain");
        // stall for three cycles mid-stream
        nxt = 32'h100;
        for (int k = 0; k < 12; k++) begin
            logic acc;
            acc = rdy_m;
            step(1'b1, nxt, !(k >= 3 && k < 6), 1'b0, "stall");
            if (acc) nxt++;
            if (k == 3) chk("stall_full", DW'(occupancy), 32'd2);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, "stall_drain");
        // FULL with A/B, flush with out_ready: A leaves, B dropped
        step(1'b1, 32'hAAAA, 1'b0, 1'b0, "fill_a");
        step(1'b1, 32'hBBBB, 1'b0, 1'b0, "fill_b");
        chk("full_head", out_data, 32'hAAAA);
        step(1'b0, '0, 1'b1, 1'b1, "flush_full");
        chk("flush_full_data", out_data, RV);
        chk("flush_full_occ", DW'(occupancy), 32'd0);
        // ONE, flush with a concurrent new beat that must never appear
        step(1'b1, 32'h1234, 1'b0, 1'b0, "one");
        step(1'b1, 32'hDEAD, 1'b0, 1'b1, "flush_one");
        chk("flush_one_ready", DW'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b1, 1'b0, "after_flush");
            chk("no_dead", DW'(out_data == 32'hDEAD), 32'd0);
        end
        // random traffic
        for (int k = 0; k < 300; k++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0, "rand");
        // asynchronous reset between edges while FULL
        step(1'b1, 32'hC0C0, 1'b0, 1'b0, "pre_rst_a");
        step(1'b1, 32'hD0D0, 1'b0, 1'b0, "pre_rst_b");
        #2 rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        q.delete(); rdy_m = 1'b0; bub_m = 0;
        #1 check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, "post_rst");
        chk("post_rst_ready", DW'(in_ready), 32'd1);
        // bubble counter saturation
        for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, 1'b0, "sat");
        chk("sat_final", DW'(bubble_cnt), 32'd15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
